dsp_unpack_acc: RTL and testbench

Receive side of the packed dual-weight DSP chain. It takes the 48-bit P result from the end of a DSP48E2 cascade, where each slice computes (w_h<<LOW_W + w_l) × feature. It splits that result into the two signed products with borrow correction, and accumulates each one over a group of beats delimited by `I_last`. The block sits between the DSP column and the output buffer, and emits one pair of saturated sums per group over a valid/ready handshake.

---
 rtl/dsp_pkg.sv | 41 ++++
 rtl/sat_acc.sv | 46 ++++
 rtl/dsp_unpack_acc.sv | 151 +++++++++++++++
 tb/tb_dsp_unpack_acc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the packed dual-weight DSP chain: field alignment
// and saturating arithmetic used by both the packing and the unpacking side.
package dsp_pkg;

  localparam int P_W       = 48;
  localparam int LOW_W_DEF = 18;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] sum;
  } sat_res_t;

  function automatic logic signed [P_W-1:0] unpack_lo(input logic signed [P_W-1:0] p,
                                                      input int low_w);
    return (p <<< (P_W - low_w)) >>> (P_W - low_w);
  endfunction

  // A negative low field has borrowed one from the high field; add it back.
  function automatic logic signed [P_W-1:0] unpack_hi(input logic signed [P_W-1:0] p,
                                                      input int low_w);
    logic signed [P_W-1:0] borrow;
    borrow = p >>> (low_w - 1);
    return (p >>> low_w) + (borrow & 48'sd1);
  endfunction

  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w);
    sat_res_t           r;
    logic signed [63:0] s;
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    s      = a + b;
    hi_lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_lim = -(64'sd1 <<< (w - 1));
    r.sat  = (s > hi_lim) || (s < lo_lim);
    r.sum  = (s > hi_lim) ? hi_lim : ((s < lo_lim) ? lo_lim : s);
    return r;
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Signed saturating accumulator: loads or adds one sample per enabled cycle and
// reports whether that step clamped.
module sat_acc
  import dsp_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] acc,
  output logic                    sat
);

  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_d;
  logic        [OUT_W:0]   step;

  function automatic logic [OUT_W:0] acc_step(input logic signed [IN_W-1:0]  d,
                                              input logic signed [OUT_W-1:0] a,
                                              input logic                    ld);
    sat_res_t r;
    r = sat_add(64'(d), ld ? 64'sd0 : 64'(a), OUT_W);
    return {r.sat, r.sum[OUT_W-1:0]};
  endfunction

  // NOTE: every always_comb output gets a value before any branch, so no latch can form.
  always_comb begin
    step  = acc_step(din, acc_q, load);
    sat   = step[OUT_W];
    acc_d = acc_q;
    if (en) acc_d = signed'(step[OUT_W-1:0]);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/dsp_unpack_acc.sv
// Splits the packed DSP cascade result into two signed products and sums each
// over an I_last-delimited group, emitting one saturated pair per group.
module dsp_unpack_acc
  import dsp_pkg::*;
#(
  parameter int LOW_W = LOW_W_DEF,
  parameter int OUT_W = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [P_W-1:0]   I_p,
  input  logic             I_valid,
  input  logic             I_last,
  output logic             O_ready,
  output logic [OUT_W-1:0] O_sum_lo,
  output logic [OUT_W-1:0] O_sum_hi,
  output logic             O_sat,
  output logic             O_valid,
  input  logic             I_out_ready
);

  localparam int HI_W = P_W - LOW_W + 1;

  function automatic logic signed [LOW_W-1:0] lo_field(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] f;
    f = unpack_lo(p, LOW_W);
    return f[LOW_W-1:0];
  endfunction

  function automatic logic signed [HI_W-1:0] hi_field(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] f;
    f = unpack_hi(p, LOW_W);
    return f[HI_W-1:0];
  endfunction

  logic                    en;
  logic                    acc_en;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q,  s1_last_d;
  logic signed [LOW_W-1:0] s1_lo_q,    s1_lo_d;
  logic signed [HI_W-1:0]  s1_hi_q,    s1_hi_d;
  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_last_q,  s2_last_d;
  logic                    first_q,    first_d;
  logic                    sat_q,      sat_d;
  logic                    o_valid_q,  o_valid_d;
  logic                    o_sat_q,    o_sat_d;
  logic signed [OUT_W-1:0] o_lo_q,     o_lo_d;
  logic signed [OUT_W-1:0] o_hi_q,     o_hi_d;
  logic signed [OUT_W-1:0] acc_lo;
  logic signed [OUT_W-1:0] acc_hi;
  logic                    step_sat_lo;
  logic                    step_sat_hi;

  // The whole pipeline freezes only while a finished pair waits downstream.
  assign en     = !o_valid_q || I_out_ready;
  assign acc_en = en && s1_valid_q;

  sat_acc #(.IN_W(LOW_W), .OUT_W(OUT_W)) u_acc_lo (
    .clk (I_clk),
    .rst (I_rst),
    .en  (acc_en),
    .load(first_q),
    .din (s1_lo_q),
    .acc (acc_lo),
    .sat (step_sat_lo)
  );

  sat_acc #(.IN_W(HI_W), .OUT_W(OUT_W)) u_acc_hi (
    .clk (I_clk),
    .rst (I_rst),
    .en  (acc_en),
    .load(first_q),
    .din (s1_hi_q),
    .acc (acc_hi),
    .sat (step_sat_hi)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    first_d    = first_q;
    sat_d      = sat_q;
    o_valid_d  = o_valid_q;
    o_sat_d    = o_sat_q;
    o_lo_d     = o_lo_q;
    o_hi_d     = o_hi_q;
    if (en) begin
      s1_valid_d = I_valid;
      s1_last_d  = I_valid && I_last;
      s1_lo_d    = lo_field(I_p);
      s1_hi_d    = hi_field(I_p);
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (s1_valid_q) begin
        first_d = s1_last_q;
        sat_d   = (first_q ? 1'b0 : sat_q) | step_sat_lo | step_sat_hi;
      end
      // A load wins over a pop in the same cycle, keeping O_valid high.
      if (s2_valid_q && s2_last_q) begin
        o_valid_d = 1'b1;
        o_lo_d    = acc_lo;
        o_hi_d    = acc_hi;
        o_sat_d   = sat_q;
      end else begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      first_q    <= 1'b1;
      sat_q      <= 1'b0;
      o_valid_q  <= 1'b0;
      o_sat_q    <= 1'b0;
      o_lo_q     <= '0;
      o_hi_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      first_q    <= first_d;
      sat_q      <= sat_d;
      o_valid_q  <= o_valid_d;
      o_sat_q    <= o_sat_d;
      o_lo_q     <= o_lo_d;
      o_hi_q     <= o_hi_d;
    end
  end

  assign O_ready  = en;
  assign O_valid  = o_valid_q;
  assign O_sat    = o_sat_q;
  assign O_sum_lo = o_lo_q;
  assign O_sum_hi = o_hi_q;

endmodule

// File: tb/tb_dsp_unpack_acc.sv
// Self-checking bench for dsp_unpack_acc: directed vector table on a 32-bit and
// an 18-bit instance, plus latency, backpressure, random scoreboard and reset cases.
module tb_dsp_unpack_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic [47:0]        i_p;
  logic               i_valid;
  logic               i_last;
  logic               out_ready;
  logic               o_ready,  o_ready18;
  logic signed [31:0] o_lo,     o_hi;
  logic signed [17:0] o_lo18,   o_hi18;
  logic               o_sat,    o_sat18;
  logic               o_valid,  o_valid18;

  always #5 clk = ~clk;

  dsp_unpack_acc #(.LOW_W(18), .OUT_W(32)) dut (
    .I_clk(clk), .I_rst(rst), .I_p(i_p), .I_valid(i_valid), .I_last(i_last),
    .O_ready(o_ready), .O_sum_lo(o_lo), .O_sum_hi(o_hi), .O_sat(o_sat),
    .O_valid(o_valid), .I_out_ready(out_ready)
  );

  dsp_unpack_acc #(.LOW_W(18), .OUT_W(18)) dut18 (
    .I_clk(clk), .I_rst(rst), .I_p(i_p), .I_valid(i_valid), .I_last(i_last),
    .O_ready(o_ready18), .O_sum_lo(o_lo18), .O_sum_hi(o_hi18), .O_sat(o_sat18),
    .O_valid(o_valid18), .I_out_ready(out_ready)
  );

  typedef struct {
    logic [47:0] p;
    bit          last;
    longint      lo32, hi32;
    bit          sat32;
    longint      lo18, hi18;
    bit          sat18;
  } vec_t;

  typedef struct {
    longint lo, hi;
    bit     sat;
    int     cyc;
  } out_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  out_t q32[$];
  out_t q18[$];
  out_t exp_q[$];
  vec_t tbl[14];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pair that will be popped at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && o_valid && out_ready)
      q32.push_back('{lo: o_lo, hi: o_hi, sat: o_sat, cyc: cyc});
    if (!rst && o_valid18 && out_ready)
      q18.push_back('{lo: o_lo18, hi: o_hi18, sat: o_sat18, cyc: cyc});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] mk_p(input longint hi, input longint lo);
    longint v;
    v = hi * 262144 + lo;
    return v[47:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] p, input bit last);
    int k    = 0;
    bit done = 0;
    i_valid = 1'b1;
    i_p     = p;
    i_last  = last;
    while (!done && k < 50) begin
      @(negedge clk);
      done = o_ready;
      tick();
      k++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_pops(input string name, input int n, input int bound);
    int k = 0;
    while (q32.size() < n && k < bound) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check(name, q32.size(), n);
  endtask

  function automatic out_t pop32();
    out_t e = '{lo: -999, hi: -999, sat: 1'b1, cyc: -1};
    if (q32.size() > 0) e = q32.pop_front();
    return e;
  endfunction

  function automatic out_t pop18();
    out_t e = '{lo: -999, hi: -999, sat: 1'b1, cyc: -1};
    if (q18.size() > 0) e = q18.pop_front();
    return e;
  endfunction

  initial begin
    out_t e, e18;
    int   gcyc[16];
    int   g;
    int   m_first;
    longint m_lo, m_hi;

    tbl[0]  = '{mk_p(-10, 15),        1, 15,      -10,        0, 15,      -10,     0};
    tbl[1]  = '{mk_p(-10, -1),        1, -1,      -10,        0, -1,      -10,     0};
    tbl[2]  = '{mk_p(3, -2),          0, 0,       0,          0, 0,       0,       0};
    tbl[3]  = '{mk_p(3, -2),          0, 0,       0,          0, 0,       0,       0};
    tbl[4]  = '{mk_p(3, -2),          0, 0,       0,          0, 0,       0,       0};
    tbl[5]  = '{mk_p(3, -2),          1, -8,      12,         0, -8,      12,      0};
    tbl[6]  = '{mk_p(1, 1),           1, 1,       1,          0, 1,       1,       0};
    tbl[7]  = '{mk_p(-536870912, 0),  1, 0,       -536870912, 0, 0,       -131072, 1};
    tbl[8]  = '{mk_p(5, -131072),     1, -131072, 5,          0, -131072, 5,       0};
    tbl[9]  = '{mk_p(536870912, -1),  1, -1,      536870912,  0, -1,      131071,  1};
    tbl[10] = '{mk_p(0, 131071),      0, 0,       0,          0, 0,       0,       0};
    tbl[11] = '{mk_p(0, 131071),      0, 0,       0,          0, 0,       0,       0};
    tbl[12] = '{mk_p(0, 131071),      1, 393213,  0,          0, 131071,  0,       1};
    tbl[13] = '{mk_p(0, 5),           1, 5,       0,          0, 5,       0,       0};

    rst       = 1'b1;
    i_valid   = 1'b0;
    i_p       = '0;
    i_last    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_o_valid", o_valid, 0);
    check("rst_o_sum_lo", o_lo, 0);
    check("rst_o_sum_hi", o_hi, 0);
    check("rst_o_sat", o_sat, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_valid18", o_valid18, 0);

    // Latency: beat accepted at edge A, result visible after edge A+2
    i_valid = 1'b1;
    i_p     = mk_p(-10, 15);
    i_last  = 1'b1;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("lat_a0_valid", o_valid, 0);
    tick();
    check("lat_a1_valid", o_valid, 0);
    tick();
    check("lat_a2_valid", o_valid, 1);
    check("lat_a2_lo", o_lo, 15);
    check("lat_a2_hi", o_hi, -10);
    repeat (3) tick();
    q32.delete();
    q18.delete();

    // Directed table, beats back to back
    for (int r = 0; r < 14; r++) begin
      i_valid = 1'b1;
      i_p     = tbl[r].p;
      i_last  = tbl[r].last;
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    wait_pops("tbl_pop_count", 9, 30);
    g = 0;
    for (int r = 0; r < 14; r++) begin
      if (tbl[r].last) begin
        e   = pop32();
        e18 = pop18();
        gcyc[g] = e.cyc;
        check($sformatf("tbl_lo32[%0d]", r), e.lo, tbl[r].lo32);
        check($sformatf("tbl_hi32[%0d]", r), e.hi, tbl[r].hi32);
        check($sformatf("tbl_sat32[%0d]", r), e.sat, tbl[r].sat32);
        check($sformatf("tbl_lo18[%0d]", r), e18.lo, tbl[r].lo18);
        check($sformatf("tbl_hi18[%0d]", r), e18.hi, tbl[r].hi18);
        check($sformatf("tbl_sat18[%0d]", r), e18.sat, tbl[r].sat18);
        g++;
      end
    end
    check("b2b_gap_single", gcyc[1] - gcyc[0], 1);
    check("b2b_gap_group", gcyc[3] - gcyc[2], 1);

    // Backpressure: three results stuck, a fourth beat held at the input
    q32.delete();
    q18.delete();
    out_ready = 1'b0;
    send(mk_p(2, 3), 1);
    send(mk_p(4, -5), 1);
    send(mk_p(6, 6), 1);
    i_valid = 1'b1;
    i_p     = mk_p(-8, 9);
    i_last  = 1'b1;
    for (int k = 0; k < 10 && !o_valid; k++) tick();
    check("bp_valid_seen", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_o_ready", o_ready, 0);
      check("bp_o_valid", o_valid, 1);
      check("bp_o_lo", o_lo, 3);
      check("bp_o_hi", o_hi, 2);
      tick();
    end
    out_ready = 1'b1;
    send(mk_p(-8, 9), 1);
    wait_pops("bp_pop_count", 4, 30);
    e = pop32(); check("bp_p0_lo", e.lo, 3);  check("bp_p0_hi", e.hi, 2);
    e = pop32(); check("bp_p1_lo", e.lo, -5); check("bp_p1_hi", e.hi, 4);
    e = pop32(); check("bp_p2_lo", e.lo, 6);  check("bp_p2_hi", e.hi, 6);
    e = pop32(); check("bp_p3_lo", e.lo, 9);  check("bp_p3_hi", e.hi, -8);

    // Random beats against a scoreboard built from the packing-side values
    q32.delete();
    q18.delete();
    m_first = 1;
    m_lo    = 0;
    m_hi    = 0;
    for (int n = 0, it = 0; n < 1000 && it < 20000; it++) begin
      longint hi, lo;
      hi        = longint'($urandom_range(0, 2000)) - 1000;
      lo        = longint'($urandom_range(0, 262143)) - 131072;
      i_valid   = ($urandom_range(0, 3) != 0);
      i_p       = mk_p(hi, lo);
      i_last    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i_valid && o_ready) begin
        if (m_first != 0) begin
          m_lo = lo;
          m_hi = hi;
        end else begin
          m_lo += lo;
          m_hi += hi;
        end
        if (i_last) begin
          exp_q.push_back('{lo: m_lo, hi: m_hi, sat: 1'b0, cyc: 0});
          m_first = 1;
        end else begin
          m_first = 0;
        end
        n++;
      end
      tick();
    end
    i_valid   = 1'b0;
    i_last    = 1'b0;
    out_ready = 1'b1;
    wait_pops("rand_pop_count", exp_q.size(), 40);
    foreach (exp_q[i]) begin
      e = pop32();
      check($sformatf("rand_lo[%0d]", i), e.lo, exp_q[i].lo);
      check($sformatf("rand_hi[%0d]", i), e.hi, exp_q[i].hi);
    end

    // Reset in the middle of a group discards the partial sums
    q32.delete();
    q18.delete();
    send(mk_p(1, 1), 0);
    send(mk_p(2, 2), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(mk_p(7, 7), 1);
    repeat (10) tick();
    check("mid_rst_pop_count", q32.size(), 1);
    e = pop32();
    check("mid_rst_lo", e.lo, 7);
    check("mid_rst_hi", e.hi, 7);
    check("mid_rst_sat", e.sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
